// File: rtl/seq_pkg.sv
// Shared types and defaults for the stack program sequencer.
// Next-PC select encoding, default sizes and the reset vector.
package seq_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_JMP,
        NPC_RET,
        NPC_LOOP
    } npc_sel_e;

    localparam int DEF_PC_W        = 8;
    localparam int DEF_STACK_DEPTH = 4;
    localparam int DEF_CNT_W       = 4;
    localparam int RESET_VEC       = 0;

endpackage

// File: rtl/seq_return_stack.sv
// Hardware return stack: depth-parametrised register file plus occupancy count.
// Pop wins over push; a push into a full stack is dropped.
module seq_return_stack
    import seq_pkg::*;
#(
    parameter int W     = DEF_PC_W,
    parameter int DEPTH = DEF_STACK_DEPTH,
    parameter int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    din,
    output logic [W-1:0]    top,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] cnt;
    logic [SP_W-1:0] top_idx;

    assign full    = (cnt == SP_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign sp      = cnt;
    assign top_idx = cnt - 1'b1;
    assign top     = mem[top_idx[IDX_W-1:0]];

    // Occupancy count; the entry storage itself is never cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (pop && !empty) begin
            cnt <= cnt - 1'b1;
        end else if (push && !pop && !full) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Write the pushed return address into the next free slot.
    always_ff @(posedge clk) begin
        if (push && !pop && !full) begin
            mem[cnt[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/stack_program_sequencer.sv
// Program sequencer: priority decode, next-PC mux, PC register, return stack.
// Optional single-level hardware loop enabled by defining LOOP_CTR_EN.
module stack_program_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                               clk,
    input  logic                               sync_reset,
    input  logic                               stall,
    input  logic                               jmp,
    input  logic                               jmp_nz,
    input  logic                               dont_jmp,
    input  logic                               call,
    input  logic                               ret,
    input  logic [PC_W-1:0]                    jmp_addr,
    input  logic                               loop_start,
    input  logic                               loop_end,
    input  logic [CNT_W-1:0]                   loop_count,
    output logic [PC_W-1:0]                    pm_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_ovf,
    output logic                               stack_unf,
    output logic                               loop_active
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    npc_sel_e        sel;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] npc;
    logic [PC_W-1:0] stk_top;
    logic [PC_W-1:0] loop_target;
    logic            stk_full;
    logic            stk_empty;
    logic            push;
    logic            pop;
    logic            set_ovf;
    logic            set_unf;
    logic            loop_load;
    logic            loop_dec;
    logic            loop_clr;

    assign pc_inc = pm_addr + 1'b1;

    seq_return_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH),
        .SP_W  (SP_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (sync_reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (stk_top),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

`ifdef LOOP_CTR_EN
    logic [CNT_W-1:0] loop_cnt;
    logic [PC_W-1:0]  body_addr;

    assign loop_active = (loop_cnt != '0);
    assign loop_target = body_addr;

    // Loop counter and body start address; frozen while stalled.
    always_ff @(posedge clk) begin
        if (!sync_reset) begin
            loop_cnt  <= '0;
            body_addr <= PC_W'(RESET_VEC);
        end else if (!stall) begin
            if (loop_load) begin
                loop_cnt  <= loop_count;
                body_addr <= pc_inc;
            end else if (loop_dec) begin
                loop_cnt <= loop_cnt - 1'b1;
            end else if (loop_clr) begin
                loop_cnt <= '0;
            end
        end
    end
`else
    logic unused_loop;

    assign unused_loop = ^{loop_start, loop_end, loop_count};
    assign loop_active = 1'b0;
    assign loop_target = pc_inc;
`endif

    // Priority decode: ret > call > jmp > jmp_nz > loop ops > sequential.
    always_comb begin
        sel       = NPC_SEQ;
        push      = 1'b0;
        pop       = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        loop_load = 1'b0;
        loop_dec  = 1'b0;
        loop_clr  = 1'b0;
        if (stall) begin
            sel = NPC_SEQ;
        end else if (ret) begin
            if (!stk_empty) begin
                sel = NPC_RET;
                pop = 1'b1;
            end else begin
                set_unf = 1'b1;
            end
        end else if (call) begin
            sel = NPC_JMP;
            if (stk_full) begin
                set_ovf = 1'b1;
            end else begin
                push = 1'b1;
            end
        end else if (jmp) begin
            sel = NPC_JMP;
        end else if (jmp_nz) begin
            if (!dont_jmp) begin
                sel = NPC_JMP;
            end
`ifdef LOOP_CTR_EN
        end else if (loop_start) begin
            loop_load = 1'b1;
        end else if (loop_end) begin
            if (loop_cnt > CNT_W'(1)) begin
                sel      = NPC_LOOP;
                loop_dec = 1'b1;
            end else begin
                loop_clr = 1'b1;
            end
`endif
        end
    end

    // Next-PC mux.
    always_comb begin
        npc = pc_inc;
        case (sel)
            NPC_SEQ:  npc = pc_inc;
            NPC_JMP:  npc = jmp_addr;
            NPC_RET:  npc = stk_top;
            NPC_LOOP: npc = loop_target;
            default:  npc = pc_inc;
        endcase
    end

    // PC register and sticky stack-error flags.
    always_ff @(posedge clk) begin
        if (!sync_reset) begin
            pm_addr   <= PC_W'(RESET_VEC);
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (!stall) begin
            pm_addr <= npc;
            if (set_ovf) begin
                stack_ovf <= 1'b1;
            end
            if (set_unf) begin
                stack_unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_program_sequencer.sv
// Scoreboard bench for stack_program_sequencer (PC_W=8, STACK_DEPTH=4).
// Stimulus queues hand-computed expectations; a monitor compares each cycle.
module tb_stack_program_sequencer;

    typedef struct packed {
        logic [7:0] pc;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
        logic       la;
    } exp_t;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic       stall;
    logic       jmp;
    logic       jmp_nz;
    logic       dont_jmp;
    logic       call;
    logic       ret;
    logic [7:0] jmp_addr;
    logic       loop_start;
    logic       loop_end;
    logic [3:0] loop_count;
    logic [7:0] pm_addr;
    logic [2:0] sp;
    logic       stack_ovf;
    logic       stack_unf;
    logic       loop_active;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    stack_program_sequencer #(
        .PC_W        (8),
        .STACK_DEPTH (4),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .stall       (stall),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .dont_jmp    (dont_jmp),
        .call        (call),
        .ret         (ret),
        .jmp_addr    (jmp_addr),
        .loop_start  (loop_start),
        .loop_end    (loop_end),
        .loop_count  (loop_count),
        .pm_addr     (pm_addr),
        .sp          (sp),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf),
        .loop_active (loop_active)
    );

    always #5 clk = ~clk;

    // Monitor: one scoreboard entry is retired per cycle on the falling edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{pm_addr, sp, stack_ovf, stack_unf, loop_active};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL check%0d: got pc=%h sp=%0d ovf=%b unf=%b la=%b, want pc=%h sp=%0d ovf=%b unf=%b la=%b",
                             n_checks, a.pc, a.sp, a.ovf, a.unf, a.la,
                             e.pc, e.sp, e.ovf, e.unf, e.la);
                end
            end
        end
    end

    task automatic cmd(input logic r, input logic c, input logic j,
                       input logic jz, input logic dj, input logic [7:0] a);
        ret      = r;
        call     = c;
        jmp      = j;
        jmp_nz   = jz;
        dont_jmp = dj;
        jmp_addr = a;
        loop_start = 1'b0;
        loop_end   = 1'b0;
    endtask

    // Clock one edge and queue the state expected right after it.
    task automatic tick(input logic [7:0] pc, input logic [2:0] s,
                        input logic o, input logic u, input logic la);
        exp_t e;
        @(posedge clk);
        e = '{pc, s, o, u, la};
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        sync_reset = 1'b0;
        stall      = 1'b0;
        loop_count = 4'd0;
        cmd(0, 0, 1, 0, 0, 8'h55);

        // Reset with a jump pending.
        tick(8'h00, 0, 0, 0, 0);
        tick(8'h00, 0, 0, 0, 0);
        sync_reset = 1'b1;

        // Sequential wrap.
        cmd(0, 0, 1, 0, 0, 8'hFE);
        tick(8'hFE, 0, 0, 0, 0);
        cmd(0, 0, 0, 0, 0, 8'h00);
        tick(8'hFF, 0, 0, 0, 0);
        tick(8'h00, 0, 0, 0, 0);
        tick(8'h01, 0, 0, 0, 0);
        tick(8'h02, 0, 0, 0, 0);
        tick(8'h03, 0, 0, 0, 0);

        // Nested call/return.
        cmd(0, 1, 0, 0, 0, 8'h10);
        tick(8'h10, 1, 0, 0, 0);
        cmd(0, 0, 0, 0, 0, 8'h00);
        tick(8'h11, 1, 0, 0, 0);
        cmd(0, 1, 0, 0, 0, 8'h20);
        tick(8'h20, 2, 0, 0, 0);
        cmd(1, 0, 0, 0, 0, 8'h00);
        tick(8'h12, 1, 0, 0, 0);
        tick(8'h04, 0, 0, 0, 0);

        // Overflow on fifth call, underflow on fifth return.
        cmd(0, 1, 0, 0, 0, 8'h30);
        tick(8'h30, 1, 0, 0, 0);
        jmp_addr = 8'h40;
        tick(8'h40, 2, 0, 0, 0);
        jmp_addr = 8'h50;
        tick(8'h50, 3, 0, 0, 0);
        jmp_addr = 8'h60;
        tick(8'h60, 4, 0, 0, 0);
        jmp_addr = 8'h70;
        tick(8'h70, 4, 1, 0, 0);
        cmd(1, 0, 0, 0, 0, 8'h00);
        tick(8'h51, 3, 1, 0, 0);
        tick(8'h41, 2, 1, 0, 0);
        tick(8'h31, 1, 1, 0, 0);
        tick(8'h05, 0, 1, 0, 0);
        tick(8'h06, 0, 1, 1, 0);

        // Priority: ret beats call and jmp.
        cmd(0, 1, 0, 0, 0, 8'h80);
        tick(8'h80, 1, 1, 1, 0);
        cmd(1, 1, 1, 0, 0, 8'h99);
        tick(8'h07, 0, 1, 1, 0);
        tick(8'h08, 0, 1, 1, 0);

        // Stall holds everything, commands lost.
        stall = 1'b1;
        cmd(0, 0, 1, 0, 0, 8'h33);
        tick(8'h08, 0, 1, 1, 0);
        tick(8'h08, 0, 1, 1, 0);
        cmd(0, 1, 0, 0, 0, 8'h44);
        tick(8'h08, 0, 1, 1, 0);
        stall = 1'b0;

        // Conditional jump, not taken then taken.
        cmd(0, 0, 0, 1, 1, 8'hC0);
        tick(8'h09, 0, 1, 1, 0);
        cmd(0, 0, 0, 1, 0, 8'hC0);
        tick(8'hC0, 0, 1, 1, 0);

`ifdef LOOP_CTR_EN
        // Hardware loop: body 06..07 runs three times.
        cmd(0, 0, 1, 0, 0, 8'h04);
        tick(8'h04, 0, 1, 1, 0);
        cmd(0, 0, 0, 0, 0, 8'h00);
        tick(8'h05, 0, 1, 1, 0);
        loop_start = 1'b1;
        loop_count = 4'd3;
        tick(8'h06, 0, 1, 1, 1);
        loop_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(8'h07, 0, 1, 1, 1);
            loop_end = 1'b1;
            tick(8'h06, 0, 1, 1, 1);
            loop_end = 1'b0;
        end
        tick(8'h07, 0, 1, 1, 1);
        loop_end = 1'b1;
        tick(8'h08, 0, 1, 1, 0);
        loop_end = 1'b0;
        tick(8'h09, 0, 1, 1, 0);
`endif

        // Reset clears sticky flags.
        sync_reset = 1'b0;
        tick(8'h00, 0, 0, 0, 0);
        sync_reset = 1'b1;
        cmd(0, 0, 0, 0, 0, 8'h00);
        tick(8'h01, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: run not finished, want finished");
            $fatal(1, "timeout");
        end
    end

endmodule
